psum_collect_ctrl: RTL
======================

Name: psum_collect_ctrl

Overview:
- Return-path bus controller that gathers results (partial sums) from the glb_PE column and merges them into one output stream toward the global buffer.
- It is the counterpart of X_BusCtrl: X_BusCtrl broadcasts tagged operands to the PEs, and this block collects tagged results back from them.
- PEs offer results with valid/ready; this block arbitrates round-robin, buffers results in a small FIFO, and counts results against a programmed total.

Parameters:
- DATA_WIDTH, 16, result word width.
- TAG_WIDTH, 8, width of the Y_TAG carried with each result.
- NUM_COL, 3, number of PE result ports.
- FIFO_DEPTH, 4, output buffer depth; must be a power of two, at least 2.
- CNT_WIDTH, 16, width of the expected-result counter.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort: clears FIFO and state.
- start  in  1  one-cycle pulse that begins a collection.
- expect_cnt  in  CNT_WIDTH  number of results to collect; sampled on start.
- pe_valid  in  NUM_COL  per-PE result valid.
- pe_data  in  NUM_COL*DATA_WIDTH  packed results; PE i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- pe_tag  in  NUM_COL*TAG_WIDTH  packed tags, packed the same way.
- pe_ready  out  NUM_COL  one-hot grant; all zero when no grant.
- out_valid  out  1  FIFO head is valid.
- out_data  out  DATA_WIDTH  head data.
- out_tag  out  TAG_WIDTH  head tag.
- out_col  out  $clog2(NUM_COL)  index of the PE that produced the head entry.
- out_ready  in  1  downstream accepts the head.
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse when a collection completes.

Behaviour:
- Reset values: every output is 0, state is IDLE, FIFO is empty, the round-robin pointer is 0, and the counter is 0.
- States:
  - IDLE: start with expect_cnt==0 goes to DONE. start with expect_cnt>0 latches the remaining count and goes to COLLECT.
  - COLLECT: grants PE results. When the accepted count reaches the latched total, go to DRAIN.
  - DRAIN: no grants are issued. When the FIFO is empty, go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- A start pulse outside IDLE is ignored.
- Grant rule (COLLECT only):
  - The grant is combinational from pe_valid, the registered FIFO full flag, and the registered remaining count.
  - pe_ready[i]=1 only if all of the following hold: pe_valid[i] is high, the FIFO is not full, remaining>0, and i is the first requester at or after the rr pointer (modulo NUM_COL).
  - A handshake is pe_valid[i] & pe_ready[i]. It pushes {data, tag, i} into the FIFO, decrements remaining, and sets the pointer to (i+1) mod NUM_COL.
  - At most one push per cycle.
- Full FIFO: no grant is issued, even if a pop happens in the same cycle. The next cycle re-evaluates the grant.
- Output side:
  - Show-ahead FIFO: out_* are driven from the head register and out_valid = !empty.
  - A pop occurs on out_valid & out_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the level unchanged.
- Latency: a handshake in cycle N with an empty FIFO gives out_valid=1 in cycle N+1 with that entry.
- Pointer wrap: with NUM_COL=3 the pointer sequence is 0→1→2→0.
- Counter: decrements only on a handshake and never underflows. When remaining reaches 0, no further grants occur in that collection.
- out_valid may remain high across DRAIN→DONE→IDLE if downstream stalls? No: DONE is entered only once the FIFO is empty.
- flush has priority over start and over all handshakes:
  - In the cycle flush is sampled high, pe_ready=0.
  - Next cycle: FIFO is empty, state is IDLE, pointer is 0, and done is not asserted.
- rst asserted mid-operation: all state is cleared immediately (asynchronously). Results already in flight are lost.
- Width rule: out_col is the zero-extended PE index.

Decomposition:
- Shared package psum_pkg holds:
  - a typedef for the FIFO entry struct {data, tag, col};
  - the state enum (IDLE, COLLECT, DRAIN, DONE);
  - a localparam function for clog2 of NUM_COL with a minimum of 1.
- One sub-module, rr_arbiter:
  - parameterised by NUM_COL;
  - inputs: req, enable, and ptr;
  - output: the one-hot grant.
- The FIFO is written inline in psum_collect_ctrl.

Test Plan:
- Basic ordering: start with expect_cnt=3; PE0, PE1 and PE2 all valid continuously with data 0x0011/0x0022/0x0033 and tags 1/2/3; out_ready=1. Required: grants go to PE0, PE1, PE2 in consecutive cycles; outputs appear in the same order with out_col 0, 1, 2; done pulses once, after the third output.
- Round-robin fairness: expect_cnt=6 with only PE0 and PE2 valid. Required: grant order is 0, 2, 0, 2, 0, 2 and PE1 is never granted.
- Backpressure: out_ready=0, FIFO_DEPTH=4, expect_cnt=6. Required: exactly 4 grants, then pe_ready stays at 0. Releasing out_ready delivers all 6 results in order, then done.
- Zero count: start with expect_cnt=0. Required: done=1 two cycles later, pe_ready never asserted, busy stays 0.
- Flush mid-collection: after 2 of 5 results, pulse flush. Required: next cycle out_valid=0, busy=0, no done; a following start with expect_cnt=1 works normally and its grant goes to PE0 (pointer was reset).
- Async reset during DRAIN: assert rst between clock edges. Required: all outputs are 0 immediately, and state is IDLE after rst deasserts.

Source files
------------

// File: rtl/psum_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
// Shared types for the partial-sum return path: the collection state enum,
// the FIFO entry layout {data, tag, col} and a clog2 helper that never
// returns less than 1 (so a single-port build still gets a 1-bit index).
// ---------------------------------------------------------------------------
package psum_pkg;

    function automatic int psum_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int PSUM_DATA_W  = 16;
    localparam int PSUM_TAG_W   = 8;
    localparam int PSUM_NUM_COL = 3;
    localparam int PSUM_COL_W   = psum_clog2(PSUM_NUM_COL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } psum_state_e;

    typedef struct packed {
        logic [PSUM_DATA_W-1:0] data;
        logic [PSUM_TAG_W-1:0]  tag;
        logic [PSUM_COL_W-1:0]  col;
    } psum_entry_t;

endpackage

// File: rtl/psum_collect_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant: picks the first requester at or after ptr (modulo
// NUM_COL). Purely combinational; the owner keeps and advances the pointer.
//   req    : per-port request
//   enable : global grant enable (all-zero grant when low)
//   ptr    : highest-priority port index
//   grant  : one-hot grant, all zero when nothing is granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import psum_pkg::*;
#(
    parameter  int NUM_COL = 3,
    localparam int PW      = psum_clog2(NUM_COL)
) (
    input  logic [NUM_COL-1:0] req,
    input  logic               enable,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_COL-1:0] grant
);

    logic found_s;
    int   idx_s;

    // Scan ports starting at ptr; the first active request wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NUM_COL; k++) begin
            idx_s = (int'(ptr) + k) % NUM_COL;
            if (enable && !found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/psum_collect_ctrl.sv
// ---------------------------------------------------------------------------
// psum_collect_ctrl
// Collects tagged partial sums from the PE column (round-robin), buffers them
// in a show-ahead FIFO and counts accepted results against expect_cnt.
//   clk, rst         : clock, async active-high reset
//   flush            : synchronous abort (empties FIFO, back to IDLE)
//   start/expect_cnt : begin a collection of expect_cnt results
//   pe_valid/data/tag: per-PE result offer, pe_ready is the one-hot grant
//   out_*            : FIFO head (data, tag, producing column), out_ready pops
//   busy             : collection or drain in progress
//   done             : one-cycle completion pulse
// ---------------------------------------------------------------------------
module psum_collect_ctrl
    import psum_pkg::*;
#(
    parameter  int DATA_WIDTH = PSUM_DATA_W,
    parameter  int TAG_WIDTH  = PSUM_TAG_W,
    parameter  int NUM_COL    = PSUM_NUM_COL,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_WIDTH  = 16,
    localparam int COL_W      = psum_clog2(NUM_COL)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           expect_cnt,
    input  logic [NUM_COL-1:0]             pe_valid,
    input  logic [NUM_COL*DATA_WIDTH-1:0]  pe_data,
    input  logic [NUM_COL*TAG_WIDTH-1:0]   pe_tag,
    output logic [NUM_COL-1:0]             pe_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic [COL_W-1:0]               out_col,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = psum_clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    psum_state_e          state_r;
    logic [CNT_WIDTH-1:0] remaining_r;
    logic [COL_W-1:0]     rr_ptr_r;
    logic                 done_r;
    logic                 busy_r;

    psum_entry_t          fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 grant_en_s;
    logic                 push_s;
    logic                 pop_s;
    logic [NUM_COL-1:0]   grant_s;
    logic [COL_W-1:0]     grant_idx_s;
    logic [COL_W-1:0]     ptr_next_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [TAG_WIDTH-1:0] sel_tag_s;
    psum_entry_t          push_entry_s;
    psum_entry_t          head_s;

    assign full_s  = (level_r == LW'(FIFO_DEPTH));
    assign empty_s = (level_r == '0);

    // Full is judged on the registered level only: a same-cycle pop does not
    // reopen the grant, and flush forces the grant low in its own cycle.
    assign grant_en_s = (state_r == ST_COLLECT) && !full_s &&
                        (remaining_r != '0) && !flush;

    rr_arbiter #(.NUM_COL(NUM_COL)) u_arb (
        .req    (pe_valid),
        .enable (grant_en_s),
        .ptr    (rr_ptr_r),
        .grant  (grant_s)
    );

    assign pe_ready = grant_s;
    assign push_s   = |(grant_s & pe_valid);
    assign pop_s    = !empty_s && out_ready;

    // Encode the one-hot grant and mux the granted PE's data and tag.
    always_comb begin
        grant_idx_s = '0;
        sel_data_s  = '0;
        sel_tag_s   = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? COL_W'(i) : '0);
            sel_data_s  = sel_data_s | (pe_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
            sel_tag_s   = sel_tag_s  | (pe_tag[i*TAG_WIDTH +: TAG_WIDTH] & {TAG_WIDTH{grant_s[i]}});
        end
    end

    assign ptr_next_s   = (grant_idx_s == COL_W'(NUM_COL - 1)) ? '0 : grant_idx_s + COL_W'(1);
    assign push_entry_s = '{data: sel_data_s, tag: sel_tag_s, col: grant_idx_s};

    assign head_s    = fifo_mem_r[rd_ptr_r];
    assign out_valid = !empty_s;
    assign out_data  = head_s.data;
    assign out_tag   = head_s.tag;
    assign out_col   = head_s.col;
    assign busy      = busy_r;
    assign done      = done_r;

    // Show-ahead FIFO storage, pointers and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Collection FSM with remaining count, rr pointer and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            rr_ptr_r    <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            remaining_r <= '0;
            rr_ptr_r    <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle
            done_r <= (state_r == ST_DONE);
            if (push_s) begin
                remaining_r <= remaining_r - CNT_WIDTH'(1);
                rr_ptr_r    <= ptr_next_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (expect_cnt == '0) begin
                            state_r <= ST_DONE;
                        end else begin
                            remaining_r <= expect_cnt;
                            state_r     <= ST_COLLECT;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (push_s && (remaining_r == CNT_WIDTH'(1))) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (empty_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
